mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch requester (I port) and its MEM-stage data requester (D port).
- Latches each request, sequences the memory access over LATENCY cycles, then returns read data with a one-cycle ready pulse.
- Ready stays low while a request waits or is in service; the datapath uses that low ready as its stall condition.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between
// the instruction-fetch port (I) and the MEM-stage data port (D).
// Ports: clk, reset_n (async, active low);
//   I: i_readM, i_address -> i_data, i_ready;
//   D: d_readM, d_writeM, d_address, d_wdata -> d_rdata, d_ready;
//   M: m_readM, m_writeM, m_address, m_wdata <- m_rdata.
// Low ready means the request is waiting or in service; the datapath stalls on it.
// Optional macro MEM_ARB_FAIR_EN: alternate grants when both ports request.
// Without the macro, D has strict priority.
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic                 gnt_d;
    logic                 op_wr;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] i_data_q;
    logic [WORD_SIZE-1:0] d_rdata_q;

    logic any_d;
    logic take;
    logic take_d;

    assign any_d = d_readM | d_writeM;
    assign take  = any_d | i_readM;

`ifdef MEM_ARB_FAIR_EN
    logic last_d;

    // D normally wins; a D grant last time yields to a waiting I.
    assign take_d = any_d & ~(i_readM & last_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && take) begin
            last_d <= take_d;
        end
    end
`else
    assign take_d = any_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= 4'd0;
            gnt_d     <= 1'b0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        gnt_d   <= take_d;
                        op_wr   <= take_d & d_writeM;
                        addr_q  <= take_d ? d_address : i_address;
                        wdata_q <= take_d ? d_wdata : '0;
                        cnt     <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (!op_wr) begin
                            if (gnt_d) d_rdata_q <= m_rdata;
                            else       i_data_q  <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_readM   = (state == BUSY) & ~op_wr;
    assign m_writeM  = (state == BUSY) & op_wr;
    assign m_address = addr_q;
    assign m_wdata   = wdata_q;
    assign i_ready   = (state == DONE) & ~gnt_d;
    assign d_ready   = (state == DONE) & gnt_d;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Checks ready/data completions and memory-side access runs.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM, d_readM, d_writeM;
    logic [15:0] i_address, d_address, d_wdata;
    logic [15:0] i_data, d_rdata, m_address, m_wdata, m_rdata;
    logic        i_ready, d_ready, m_readM, m_writeM;

    logic        i_readM1;
    logic [15:0] i_address1;
    logic [15:0] i_data1, d_rdata1, m_address1, m_wdata1, m_rdata1;
    logic        i_ready1, d_ready1, m_readM1, m_writeM1;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0000;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int i_cnt = 0;
    int d_cnt = 0;

    typedef struct {
        bit          d;
        logic [15:0] data;
    } rdy_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          n;
    } acc_t;

    rdy_t rdy_q[$];
    rdy_t rdy1_q[$];
    acc_t acc_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        acc_cyc <= (m_readM || m_writeM) ? acc_cyc + 1 : 0;
    end

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hA5A5;
            16'h0030: return 16'hC3C3;
            16'h0001: return 16'h0F0F;
            16'h0050: return 16'h5A5A;
            16'h00FF: return 16'hBEEF;
            default:  return 16'h0000;
        endcase
    endfunction

    // Data is only valid on the final access cycle.
    assign m_rdata  = (m_readM && acc_cyc == LAT - 1) ?
                      mem_rd(m_address) : 16'hDEAD;
    assign m_rdata1 = m_readM1 ? mem_rd(m_address1) : 16'hDEAD;

    mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_address(i_address),
        .i_data(i_data), .i_ready(i_ready),
        .d_readM(d_readM), .d_writeM(d_writeM),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_readM(m_readM), .m_writeM(m_writeM),
        .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM1), .i_address(i_address1),
        .i_data(i_data1), .i_ready(i_ready1),
        .d_readM(zero1), .d_writeM(zero1),
        .d_address(zero16), .d_wdata(zero16),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .m_readM(m_readM1), .m_writeM(m_writeM1),
        .m_address(m_address1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_rdy(input bit d, input logic [15:0] data);
        rdy_t e;
        if (rdy_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rdy_unexpected: got port %0d data %0h", d, data);
        end else begin
            e = rdy_q.pop_front();
            check("rdy_port", 64'(d), 64'(e.d));
            check("rdy_data", 64'(data), 64'(e.data));
        end
    endtask

    // Completion monitor
    initial forever begin
        @(negedge clk);
        if (i_ready) begin
            i_cnt++;
            pop_rdy(1'b0, i_data);
        end
        if (d_ready) begin
            d_cnt++;
            pop_rdy(1'b1, d_rdata);
        end
        if (i_ready1 || d_ready1) begin
            rdy_t e;
            if (rdy1_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rdy1_unexpected: got data %0h", i_data1);
            end else begin
                e = rdy1_q.pop_front();
                check("rdy1_port", 64'(d_ready1), 64'(e.d));
                check("rdy1_data", 64'(i_data1), 64'(e.data));
            end
        end
    end

    // Memory-side monitor: one entry per contiguous strobe run
    initial begin
        bit   in_acc = 0;
        bit   stable = 1;
        acc_t cur;
        acc_t e;
        forever begin
            @(negedge clk);
            if (m_readM || m_writeM) begin
                if (!in_acc) begin
                    in_acc    = 1;
                    stable    = 1;
                    cur.wr    = m_writeM;
                    cur.addr  = m_address;
                    cur.wdata = m_wdata;
                    cur.n     = 1;
                end else begin
                    cur.n++;
                    if (m_address != cur.addr || m_writeM != cur.wr ||
                        (cur.wr && m_wdata != cur.wdata))
                        stable = 0;
                end
            end else if (in_acc) begin
                in_acc = 0;
                if (acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL acc_unexpected: got addr %0h", cur.addr);
                end else begin
                    e = acc_q.pop_front();
                    check("acc_wr", 64'(cur.wr), 64'(e.wr));
                    check("acc_addr", 64'(cur.addr), 64'(e.addr));
                    if (e.wr) check("acc_wdata", 64'(cur.wdata), 64'(e.wdata));
                    check("acc_len", 64'(cur.n), 64'(e.n));
                    check("acc_stable", 64'(stable), 64'd1);
                end
            end
        end
    end

    task automatic wait_rdy(input bit d, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (d ? d_ready : i_ready) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL timeout_%s: got no ready expected ready", d ? "d" : "i");
    endtask

    task automatic push_acc(input bit wr, input logic [15:0] a,
                            input logic [15:0] w, input int n);
        acc_t e;
        e.wr = wr; e.addr = a; e.wdata = w; e.n = n;
        acc_q.push_back(e);
    endtask

    task automatic push_rdy(input bit d, input logic [15:0] data);
        rdy_t e;
        e.d = d; e.data = data;
        rdy_q.push_back(e);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_strobes"}, 64'({i_ready, d_ready, m_readM, m_writeM}), 64'd0);
        check({nm, "_data"}, {i_data, d_rdata, m_address, m_wdata}, 64'd0);
    endtask

    initial begin
        int c0, td, ti, i0, d0, got;
        reset_n = 0;
        i_readM = 0; d_readM = 0; d_writeM = 0;
        i_address = 0; d_address = 0; d_wdata = 0;
        i_readM1 = 0; i_address1 = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1;
        @(negedge clk);
        check_zero("post_reset");

        // D read
        push_acc(0, 16'h0030, 0, LAT);
        push_rdy(1, 16'hC3C3);
        c0 = cyc;
        d_readM = 1; d_address = 16'h0030;
        wait_rdy(1, 20);
        check("lat_d_read", 64'(cyc - c0), 64'(LAT + 1));
        d_readM = 0;

        // D write leaves d_rdata alone
        @(negedge clk);
        push_acc(1, 16'h0020, 16'h1234, LAT);
        push_rdy(1, 16'hC3C3);
        d_writeM = 1; d_address = 16'h0020; d_wdata = 16'h1234;
        wait_rdy(1, 20);
        d_writeM = 0;

        // I read alone
        @(negedge clk);
        d0 = d_cnt;
        push_acc(0, 16'h0010, 0, LAT);
        push_rdy(0, 16'hA5A5);
        c0 = cyc;
        i_readM = 1; i_address = 16'h0010;
        wait_rdy(0, 20);
        check("lat_i_read", 64'(cyc - c0), 64'(LAT + 1));
        i_readM = 0;
        repeat (2) @(negedge clk);
        check("i_read_no_dready", 64'(d_cnt - d0), 64'd0);

        // Simultaneous: D first, then I
        push_acc(0, 16'h0030, 0, LAT);
        push_acc(0, 16'h0001, 0, LAT);
        push_rdy(1, 16'hC3C3);
        push_rdy(0, 16'h0F0F);
        i_readM = 1; i_address = 16'h0001;
        d_readM = 1; d_address = 16'h0030;
        wait_rdy(1, 20);
        td = cyc;
        d_readM = 0;
        wait_rdy(0, 20);
        ti = cyc;
        i_readM = 0;
        check("simul_gap", 64'(ti - td), 64'(LAT + 2));

        // Both held for five accesses
        @(negedge clk);
        i0 = i_cnt;
`ifdef MEM_ARB_FAIR_EN
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                push_acc(0, 16'h0030, 0, LAT);
                push_rdy(1, 16'hC3C3);
            end else begin
                push_acc(0, 16'h0001, 0, LAT);
                push_rdy(0, 16'h0F0F);
            end
        end
`else
        for (int k = 0; k < 5; k++) begin
            push_acc(0, 16'h0030, 0, LAT);
            push_rdy(1, 16'hC3C3);
        end
`endif
        i_readM = 1; d_readM = 1;
        got = 0;
        for (int k = 0; k < 60 && got < 5; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) got++;
        end
        check("hold_grants", 64'(got), 64'd5);
        i_readM = 0; d_readM = 0;
        repeat (3) @(negedge clk);
`ifdef MEM_ARB_FAIR_EN
        check("hold_i_grants", 64'(i_cnt - i0), 64'd2);
`else
        check("hold_i_starved", 64'(i_cnt - i0), 64'd0);
`endif

        // Reset mid-access, then fresh access
        push_acc(0, 16'h0050, 0, 1);
        push_acc(0, 16'h0050, 0, LAT);
        push_rdy(0, 16'h5A5A);
        i_readM = 1; i_address = 16'h0050;
        @(negedge clk);
        check("busy_before_reset", 64'(m_readM), 64'd1);
        #1 reset_n = 0;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        check_zero("held_reset");
        reset_n = 1;
        c0 = cyc;
        wait_rdy(0, 20);
        check("lat_after_reset", 64'(cyc - c0), 64'(LAT + 1));
        i_readM = 0;
        repeat (2) @(negedge clk);

        // LATENCY=1 instance
        begin
            rdy_t e;
            int   nrd;
            bit   seen;
            e.d = 0; e.data = 16'hBEEF;
            rdy1_q.push_back(e);
            nrd = 0;
            seen = 0;
            c0 = cyc;
            i_readM1 = 1; i_address1 = 16'h00FF;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (m_readM1) nrd++;
                if (i_ready1) seen = 1;
            end
            i_readM1 = 0;
            check("lat1_seen", 64'(seen), 64'd1);
            check("lat1_strobe_len", 64'(nrd), 64'd1);
            check("lat1_latency", 64'(cyc - c0), 64'd2);
        end

        repeat (4) @(negedge clk);
        check("rdy_q_drained", 64'(rdy_q.size()), 64'd0);
        check("acc_q_drained", 64'(acc_q.size()), 64'd0);
        check("rdy1_q_drained", 64'(rdy1_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
